// File: rtl/fp_divsqrt_arbiter_if.sv
// Requester and fp_unit handshake bundle for fp_divsqrt_arbiter.
// The arbiter takes the slave modport; requesters plus the fp_unit side take master.
interface fp_divsqrt_arbiter_if #(
  parameter int unsigned NReq = 4
);
  logic [NReq-1:0]    req_valid;
  logic [NReq-1:0]    req_sqrt;
  logic [NReq*32-1:0] req_data1;
  logic [NReq*32-1:0] req_data2;
  logic [NReq*3-1:0]  req_rm;
  logic [NReq-1:0]    req_ack;
  logic [NReq-1:0]    resp_valid;
  logic [31:0]        resp_result;
  logic [4:0]         resp_flags;
  logic               fpu_enable;
  logic [31:0]        fpu_data1;
  logic [31:0]        fpu_data2;
  logic [2:0]         fpu_rm;
  logic               fpu_fdiv;
  logic               fpu_fsqrt;
  logic               fpu_ready;
  logic [31:0]        fpu_result;
  logic [4:0]         fpu_flags;

  modport master (
    output req_valid, req_sqrt, req_data1, req_data2, req_rm,
    input  req_ack, resp_valid, resp_result, resp_flags,
    input  fpu_enable, fpu_data1, fpu_data2, fpu_rm, fpu_fdiv, fpu_fsqrt,
    output fpu_ready, fpu_result, fpu_flags
  );

  modport slave (
    input  req_valid, req_sqrt, req_data1, req_data2, req_rm,
    output req_ack, resp_valid, resp_result, resp_flags,
    output fpu_enable, fpu_data1, fpu_data2, fpu_rm, fpu_fdiv, fpu_fsqrt,
    input  fpu_ready, fpu_result, fpu_flags
  );
endinterface

// File: rtl/fp_divsqrt_arbiter.sv
// Round-robin sharing of one iterative fp div/sqrt unit among NReq requesters, one op in flight.
// Optional FP_ARB_TIMEOUT_EN: force completion with a qNaN/NV result after Timeout WAIT cycles.
module fp_divsqrt_arbiter #(
  parameter int unsigned NReq    = 4,
  parameter int unsigned Timeout = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  fp_divsqrt_arbiter_if.slave  bus_io,
  output logic                 timeout_err_o
);

  localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1;

  if (NReq < 2 || NReq > 8 || Timeout < 1) begin : g_param_check
    $error("fp_divsqrt_arbiter: unsupported NReq/Timeout");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [IdxW-1:0] ptr_q, grant_q;
  logic [NReq-1:0] req_ack_q, resp_valid_q;
  logic [31:0]     resp_result_q;
  logic [4:0]      resp_flags_q;
  logic            fpu_enable_q, fpu_fdiv_q, fpu_fsqrt_q;
  logic [31:0]     fpu_data1_q, fpu_data2_q;
  logic [2:0]      fpu_rm_q;
  logic            timeout_err_q;

`ifdef FP_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(Timeout + 1);
  logic [CntW-1:0] cnt_q;
`endif

  logic [IdxW-1:0] pick;
  logic            pick_vld;
  logic            sel_sqrt;
  logic [31:0]     sel_d1, sel_d2;
  logic [2:0]      sel_rm;

  function automatic logic [NReq-1:0] onehot(logic [IdxW-1:0] idx);
    logic [NReq-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // First valid requester strictly after the pointer, wrapping around.
  always_comb begin
    int unsigned cand;
    pick     = ptr_q;
    pick_vld = 1'b0;
    cand     = 0;
    for (int unsigned i = 1; i <= NReq; i++) begin
      cand = (32'(ptr_q) + i) % NReq;
      if (!pick_vld && bus_io.req_valid[cand]) begin
        pick     = IdxW'(cand);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_sqrt = bus_io.req_sqrt[pick];
    sel_d1   = bus_io.req_data1[32*int'(pick) +: 32];
    sel_d2   = bus_io.req_data2[32*int'(pick) +: 32];
    sel_rm   = bus_io.req_rm[3*int'(pick) +: 3];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      ptr_q         <= IdxW'(NReq - 1);
      grant_q       <= '0;
      req_ack_q     <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      fpu_enable_q  <= 1'b0;
      fpu_fdiv_q    <= 1'b0;
      fpu_fsqrt_q   <= 1'b0;
      fpu_data1_q   <= '0;
      fpu_data2_q   <= '0;
      fpu_rm_q      <= '0;
      timeout_err_q <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            grant_q      <= pick;
            req_ack_q    <= onehot(pick);
            fpu_enable_q <= 1'b1;
            fpu_fdiv_q   <= !sel_sqrt;
            fpu_fsqrt_q  <= sel_sqrt;
            fpu_data1_q  <= sel_d1;
            fpu_data2_q  <= sel_sqrt ? 32'h0 : sel_d2;
            fpu_rm_q     <= sel_rm;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          req_ack_q    <= '0;
          fpu_enable_q <= 1'b0;
          fpu_fdiv_q   <= 1'b0;
          fpu_fsqrt_q  <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
          cnt_q        <= '0;
`endif
          state_q      <= StWait;
        end
        StWait: begin
          // A ready on the expiry cycle takes priority over the forced result.
          if (bus_io.fpu_ready) begin
            resp_valid_q  <= onehot(grant_q);
            resp_result_q <= bus_io.fpu_result;
            resp_flags_q  <= bus_io.fpu_flags;
            state_q       <= StResp;
          end
`ifdef FP_ARB_TIMEOUT_EN
          else if (cnt_q == CntW'(Timeout - 1)) begin
            cnt_q         <= CntW'(Timeout);
            resp_valid_q  <= onehot(grant_q);
            resp_result_q <= 32'h7FC0_0000;
            resp_flags_q  <= 5'h10;
            timeout_err_q <= 1'b1;
            state_q       <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          resp_valid_q <= '0;
          ptr_q        <= grant_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.req_ack     = req_ack_q;
  assign bus_io.resp_valid  = resp_valid_q;
  assign bus_io.resp_result = resp_result_q;
  assign bus_io.resp_flags  = resp_flags_q;
  assign bus_io.fpu_enable  = fpu_enable_q;
  assign bus_io.fpu_fdiv    = fpu_fdiv_q;
  assign bus_io.fpu_fsqrt   = fpu_fsqrt_q;
  assign bus_io.fpu_data1   = fpu_data1_q;
  assign bus_io.fpu_data2   = fpu_data2_q;
  assign bus_io.fpu_rm      = fpu_rm_q;
  assign timeout_err_o      = timeout_err_q;

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// Directed bench for fp_divsqrt_arbiter: vector table plus multi-cycle sequences,
// with a behavioural fp_unit stub of configurable latency.
module tb_fp_divsqrt_arbiter;
  localparam int unsigned NReq    = 4;
  localparam int unsigned Timeout = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic timeout_err;

  always #5 clk = ~clk;

  fp_divsqrt_arbiter_if #(.NReq(NReq)) bus ();

  fp_divsqrt_arbiter #(.NReq(NReq), .Timeout(Timeout)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus_io        (bus),
    .timeout_err_o (timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // fp_unit stub: two known IEEE cases, otherwise an easily hand-computed function.
  function automatic logic [36:0] fpu_model(logic [31:0] a, logic [31:0] b, logic [2:0] rm,
                                            logic sq);
    if (!sq && a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h3F00_0000, 5'h00};
    if (sq && a[31] && a[30:0] != 31'h0) return {32'h7FC0_0000, 5'h10};
    return {a ^ b, sq, 1'b0, rm};
  endfunction

  int          stub_lat  = 2;
  bit          stub_on   = 1'b1;
  int          kick_req  = 0;
  int          kick_done = 0;
  int          n_enable  = 0;

  initial begin
    bit          busy;
    int          cnt;
    logic [31:0] s_d1, s_d2;
    logic [2:0]  s_rm;
    logic        s_sq;
    busy = 1'b0; cnt = 0; s_d1 = '0; s_d2 = '0; s_rm = '0; s_sq = 1'b0;
    bus.fpu_ready  = 1'b0;
    bus.fpu_result = '0;
    bus.fpu_flags  = '0;
    forever begin
      @(posedge clk); #2;
      bus.fpu_ready = 1'b0;
      if (!rst_n) busy = 1'b0;
      if (kick_req != kick_done) begin
        kick_done = kick_req;
        bus.fpu_ready = 1'b1;
        {bus.fpu_result, bus.fpu_flags} = {32'hDEAD_0001, 5'h1F};
      end else if (busy) begin
        if (cnt == 0) begin
          busy = 1'b0;
          bus.fpu_ready = 1'b1;
          {bus.fpu_result, bus.fpu_flags} = fpu_model(s_d1, s_d2, s_rm, s_sq);
        end else begin
          cnt--;
        end
      end
      if (rst_n && stub_on && bus.fpu_enable) begin
        n_enable++;
        s_d1 = bus.fpu_data1; s_d2 = bus.fpu_data2; s_rm = bus.fpu_rm; s_sq = bus.fpu_fsqrt;
        busy = 1'b1;
        cnt  = stub_lat;
      end
    end
  end

  int          ack_log[$];
  int          resp_log[$];
  logic [36:0] resp_data_log[$];
  int          mon_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(bus.req_ack) || !$onehot0(bus.resp_valid)) mon_err++;
      if ((bus.fpu_fdiv || bus.fpu_fsqrt) && !bus.fpu_enable) mon_err++;
      if (bus.fpu_fdiv && bus.fpu_fsqrt) mon_err++;
      for (int k = 0; k < NReq; k++) begin
        if (bus.req_ack[k]) ack_log.push_back(k);
        if (bus.resp_valid[k]) begin
          resp_log.push_back(k);
          resp_data_log.push_back({bus.resp_result, bus.resp_flags});
        end
      end
    end
  end

  bit auto_drop = 1'b1;

  // Requesters drop req_valid once acked unless the bench is holding it.
  task automatic tick();
    @(posedge clk); #1;
    if (auto_drop) bus.req_valid = bus.req_valid & ~bus.req_ack;
  endtask

  task automatic set_req(input int k, input bit sq, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [2:0] rm);
    bus.req_sqrt[k]          = sq;
    bus.req_data1[32*k +: 32] = d1;
    bus.req_data2[32*k +: 32] = d2;
    bus.req_rm[3*k +: 3]      = rm;
    bus.req_valid[k]          = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output int waited);
    waited = 0;
    while (bus.req_ack == '0 && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  task automatic wait_resp(input int budget, output int waited);
    waited = 0;
    while (bus.resp_valid == '0 && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int ack_at(int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  function automatic int resp_at(int i);
    return (i < resp_log.size()) ? resp_log[i] : -1;
  endfunction

  function automatic logic [36:0] rdata_at(int i);
    return (i < resp_data_log.size()) ? resp_data_log[i] : 37'h0;
  endfunction

  typedef struct {
    int          k;
    bit          sq;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  rm;
    logic [3:0]  rv;
    logic [31:0] res;
    logic [4:0]  fl;
    logic [31:0] fd2;
  } vec_t;

  vec_t vt[5];

  initial begin
    int w, abase, rbase, en0;
    vt[0] = '{0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 4'b0001, 32'h3F00_0000, 5'h00,
              32'h4000_0000};
    vt[1] = '{3, 1'b1, 32'hBF80_0000, 32'h1234_5678, 3'd0, 4'b1000, 32'h7FC0_0000, 5'h10,
              32'h0000_0000};
    vt[2] = '{1, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 3'd1, 4'b0010, 32'h1234_A987, 5'h01,
              32'h0000_FFFF};
    vt[3] = '{2, 1'b1, 32'h4080_0000, 32'hDEAD_BEEF, 3'd4, 4'b0100, 32'h4080_0000, 5'h14,
              32'h0000_0000};
    vt[4] = '{0, 1'b0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 3'd3, 4'b0001, 32'hF0F0_F0F0, 5'h03,
              32'h0F0F_0F0F};

    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_sqrt = '0; bus.req_data1 = '0; bus.req_data2 = '0;
    bus.req_rm = '0;
    repeat (3) tick();
    chk("rst_req_ack", 32'(bus.req_ack), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_result", bus.resp_result, 0);
    chk("rst_resp_flags", 32'(bus.resp_flags), 0);
    chk("rst_fpu_enable", 32'(bus.fpu_enable), 0);
    chk("rst_fpu_data1", bus.fpu_data1, 0);
    chk("rst_fpu_data2", bus.fpu_data2, 0);
    chk("rst_fpu_rm", 32'(bus.fpu_rm), 0);
    chk("rst_fpu_ops", 32'({bus.fpu_fdiv, bus.fpu_fsqrt}), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst_n = 1'b1;
    tick();

    // All four at once after reset: served 0,1,2,3.
    abase = ack_log.size(); rbase = resp_log.size(); en0 = n_enable;
    set_req(0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 3'd0);
    set_req(1, 1'b0, 32'h0000_0011, 32'h0000_0101, 3'd2);
    set_req(2, 1'b1, 32'h4080_0000, 32'h5555_5555, 3'd1);
    set_req(3, 1'b0, 32'hAAAA_0000, 32'h0000_AAAA, 3'd4);
    w = 0;
    while (resp_log.size() - rbase < 4 && w < 200) begin
      tick();
      w++;
    end
    repeat (4) tick();
    chk("all4_ack_count", 32'(ack_log.size() - abase), 4);
    chk("all4_resp_count", 32'(resp_log.size() - rbase), 4);
    chk("all4_enable_count", 32'(n_enable - en0), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("all4_ack_order[%0d]", i), 32'(ack_at(abase + i)), 32'(i));
      chk($sformatf("all4_resp_order[%0d]", i), 32'(resp_at(rbase + i)), 32'(i));
    end
    chk("all4_res0", rdata_at(rbase + 0)[36:5], 32'h3F00_0000);
    chk("all4_res1", rdata_at(rbase + 1)[36:5], 32'h0000_0110);
    chk("all4_flg1", 32'(rdata_at(rbase + 1)[4:0]), 32'h02);
    chk("all4_res2", rdata_at(rbase + 2)[36:5], 32'h4080_0000);
    chk("all4_flg2", 32'(rdata_at(rbase + 2)[4:0]), 32'h11);
    chk("all4_res3", rdata_at(rbase + 3)[36:5], 32'hAAAA_AAAA);
    chk("all4_flg3", 32'(rdata_at(rbase + 3)[4:0]), 32'h04);

    // Single-requester vectors: latency, issued operands, routed result, hold behaviour.
    for (int v = 0; v < 5; v++) begin
      set_req(vt[v].k, vt[v].sq, vt[v].d1, vt[v].d2, vt[v].rm);
      wait_ack(10, w);
      chk($sformatf("v%0d_ack_latency", v), 32'(w), 1);
      chk($sformatf("v%0d_ack", v), 32'(bus.req_ack), 32'(vt[v].rv));
      chk($sformatf("v%0d_enable", v), 32'(bus.fpu_enable), 1);
      chk($sformatf("v%0d_data1", v), bus.fpu_data1, vt[v].d1);
      chk($sformatf("v%0d_data2", v), bus.fpu_data2, vt[v].fd2);
      chk($sformatf("v%0d_rm", v), 32'(bus.fpu_rm), 32'(vt[v].rm));
      chk($sformatf("v%0d_ops", v), 32'({bus.fpu_fdiv, bus.fpu_fsqrt}), 32'({!vt[v].sq, vt[v].sq}));
      wait_resp(50, w);
      chk($sformatf("v%0d_resp_latency", v), 32'(w), 4);
      chk($sformatf("v%0d_resp_valid", v), 32'(bus.resp_valid), 32'(vt[v].rv));
      chk($sformatf("v%0d_result", v), bus.resp_result, vt[v].res);
      chk($sformatf("v%0d_flags", v), 32'(bus.resp_flags), 32'(vt[v].fl));
      tick();
      chk($sformatf("v%0d_resp_drop", v), 32'(bus.resp_valid), 0);
      chk($sformatf("v%0d_result_hold", v), bus.resp_result, vt[v].res);
      chk($sformatf("v%0d_data1_hold", v), bus.fpu_data1, vt[v].d1);
    end

    // Req1 and req2 held continuously: grants alternate 1,2,1,2.
    do_reset();
    auto_drop = 1'b0;
    abase = ack_log.size();
    set_req(1, 1'b0, 32'h0000_0001, 32'h0000_0002, 3'd0);
    set_req(2, 1'b0, 32'h0000_0003, 32'h0000_0004, 3'd0);
    w = 0;
    while (ack_log.size() - abase < 4 && w < 100) begin
      tick();
      w++;
    end
    bus.req_valid = '0;
    auto_drop = 1'b1;
    repeat (10) tick();
    chk("alt_ack_count", 32'(ack_log.size() - abase), 4);
    chk("alt_ack0", 32'(ack_at(abase + 0)), 1);
    chk("alt_ack1", 32'(ack_at(abase + 1)), 2);
    chk("alt_ack2", 32'(ack_at(abase + 2)), 1);
    chk("alt_ack3", 32'(ack_at(abase + 3)), 2);

    // Reset while in WAIT, then a stray fpu_ready: no response, req0 first afterwards.
    stub_lat = 10;
    set_req(2, 1'b0, 32'h0000_0005, 32'h0000_0006, 3'd0);
    wait_ack(10, w);
    chk("rw_ack", 32'(bus.req_ack), 32'h4);
    repeat (2) tick();
    rbase = resp_log.size();
    rst_n = 1'b0;
    #1;
    chk("rw_async_enable", 32'(bus.fpu_enable), 0);
    chk("rw_async_resp", 32'(bus.resp_valid), 0);
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    kick_req++;
    repeat (5) tick();
    chk("rw_no_resp", 32'(resp_log.size() - rbase), 0);
    stub_lat = 2;
    set_req(3, 1'b0, 32'h0000_0007, 32'h0000_0008, 3'd0);
    set_req(0, 1'b0, 32'h0000_0009, 32'h0000_000A, 3'd0);
    wait_ack(10, w);
    chk("rw_first_ack", 32'(bus.req_ack), 32'h1);
    wait_resp(50, w);
    chk("rw_resp0", 32'(bus.resp_valid), 32'h1);
    chk("rw_result0", bus.resp_result, 32'h0000_0003);
    tick();
    wait_resp(50, w);
    chk("rw_resp3", 32'(bus.resp_valid), 32'h8);
    chk("rw_result3", bus.resp_result, 32'h0000_000F);
    repeat (2) tick();

`ifdef FP_ARB_TIMEOUT_EN
    stub_on = 1'b0;
    set_req(1, 1'b1, 32'h4000_0000, 32'h0, 3'd0);
    wait_ack(10, w);
    chk("to_ack", 32'(bus.req_ack), 32'h2);
    wait_resp(Timeout + 20, w);
    chk("to_latency", 32'(w), 32'(Timeout + 1));
    chk("to_resp_valid", 32'(bus.resp_valid), 32'h2);
    chk("to_result", bus.resp_result, 32'h7FC0_0000);
    chk("to_flags", 32'(bus.resp_flags), 32'h10);
    tick();
    chk("to_err_sticky", 32'(timeout_err), 1);
    stub_on = 1'b1;
`else
    chk("no_timeout_err", 32'(timeout_err), 0);
`endif

    chk("monitor_violations", 32'(mon_err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
